// File: rtl/sips4_pkg.sv
// SIPS4 shared definitions: opcodes, condition codes,
// flag bit positions and controller FSM states.
package sips4_pkg;

   localparam logic [4:0] OP_JMP  = 5'b10000;
   localparam logic [4:0] OP_BCC  = 5'b10001;
   localparam logic [4:0] OP_JAL  = 5'b10010;
   localparam logic [4:0] OP_LD   = 5'b10100;
   localparam logic [4:0] OP_ST   = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_HALT = 5'b11111;

   localparam logic [2:0] CC_AL = 3'b000;
   localparam logic [2:0] CC_Z  = 3'b001;
   localparam logic [2:0] CC_NZ = 3'b010;
   localparam logic [2:0] CC_C  = 3'b011;
   localparam logic [2:0] CC_NC = 3'b100;
   localparam logic [2:0] CC_N  = 3'b101;
   localparam logic [2:0] CC_NN = 3'b110;
   localparam logic [2:0] CC_V  = 3'b111;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_LOAD2,
      ST_HALT
   } state_t;

endpackage

// File: rtl/sips4_controller_if.sv
// Controller <-> datapath bundle: instruction and ALU
// flags in, strobes and debug state out.
interface sips4_controller_if #(
   parameter int CNT_W = 16
);

   logic [15:0]      Inst;
   logic [3:0]       ALUFlags;
   logic             RegWrite;
   logic             MemWrite;
   logic             ALUSrc;
   logic             PCSrc;
   logic             PortWrite;
   logic [3:0]       ALUControl;
   logic [3:0]       Flags;
   logic             Halted;
   logic [CNT_W-1:0] Retired;

   modport master (
      output Inst, ALUFlags,
      input  RegWrite, MemWrite, ALUSrc, PCSrc,
      input  PortWrite, ALUControl, Flags,
      input  Halted, Retired
   );

   modport slave (
      input  Inst, ALUFlags,
      output RegWrite, MemWrite, ALUSrc, PCSrc,
      output PortWrite, ALUControl, Flags,
      output Halted, Retired
   );

endinterface

// File: rtl/sips4_cond_eval.sv
// Branch condition evaluation against the latched
// {N,Z,C,V} flag register.
module sips4_cond_eval
   import sips4_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         CC_AL: taken = 1'b1;
         CC_Z:  taken = flags[FLG_Z];
         CC_NZ: taken = ~flags[FLG_Z];
         CC_C:  taken = flags[FLG_C];
         CC_NC: taken = ~flags[FLG_C];
         CC_N:  taken = flags[FLG_N];
         CC_NN: taken = ~flags[FLG_N];
         CC_V:  taken = flags[FLG_V];
      endcase
   end

endmodule

// File: rtl/sips4_controller.sv
// SIPS4 control stage: instruction decode, flag register,
// two-cycle load sequencing, HALT and retired counter.
module sips4_controller
   import sips4_pkg::*;
#(
   parameter int         CNT_W  = 16,
   parameter logic [3:0] CMP_OP = 4'b1111
) (
   input logic               clk,
   input logic               reset,
   sips4_controller_if.slave bus
);

   state_t           state;
   state_t           nxt;
   logic [3:0]       flags;
   logic [CNT_W-1:0] retired;

   logic [4:0] op;
   logic       taken;
   logic       flg_ld;
   logic       ret_inc;

   logic       reg_wr;
   logic       mem_wr;
   logic       alu_src;
   logic       pc_src;
   logic       port_wr;
   logic [3:0] alu_ctl;

   logic       unused_inst;

   assign op          = bus.Inst[15:11];
   assign unused_inst = ^bus.Inst[10:4];

   sips4_cond_eval u_cond (
      .cond  (bus.Inst[3:1]),
      .flags (flags),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RUN;
         flags   <= '0;
         retired <= '0;
      end else begin
         state <= nxt;
         if (flg_ld)
            flags <= bus.ALUFlags;
         if (ret_inc)
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      nxt     = state;
      flg_ld  = 1'b0;
      ret_inc = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      alu_src = 1'b0;
      pc_src  = 1'b0;
      port_wr = 1'b0;
      alu_ctl = 4'b0000;
      unique case (state)
         ST_RUN: begin
            ret_inc = 1'b1;
            unique case (1'b1)
               !op[4]: begin
                  alu_ctl = op[3:0];
                  alu_src = bus.Inst[0];
                  reg_wr  = (op[3:0] != CMP_OP);
                  flg_ld  = 1'b1;
               end
               op == OP_JMP: begin
                  pc_src  = 1'b1;
                  alu_src = bus.Inst[0];
               end
               op == OP_BCC: begin
                  pc_src  = taken;
                  alu_src = bus.Inst[0];
               end
               op == OP_JAL: begin
                  pc_src  = 1'b1;
                  reg_wr  = 1'b1;
                  alu_src = bus.Inst[0];
               end
               op == OP_LD: begin
                  nxt     = ST_LOAD2;
                  ret_inc = 1'b0;
               end
               op == OP_ST: mem_wr = 1'b1;
               op == OP_IN: begin
                  reg_wr  = 1'b1;
                  alu_src = 1'b1;
               end
               op == OP_OUT: begin
                  port_wr = 1'b1;
                  alu_src = 1'b1;
               end
               // PC already spins on the HALT word's own address
               op == OP_HALT: begin
                  nxt     = ST_HALT;
                  pc_src  = 1'b1;
                  alu_src = 1'b1;
               end
               default: ;
            endcase
         end
         ST_LOAD2: begin
            reg_wr  = 1'b1;
            ret_inc = 1'b1;
            nxt     = ST_RUN;
         end
         ST_HALT: begin
            pc_src  = 1'b1;
            alu_src = 1'b1;
         end
         default: nxt = ST_RUN;
      endcase
   end

   assign bus.RegWrite   = reg_wr;
   assign bus.MemWrite   = mem_wr;
   assign bus.ALUSrc     = alu_src;
   assign bus.PCSrc      = pc_src;
   assign bus.PortWrite  = port_wr;
   assign bus.ALUControl = alu_ctl;
   assign bus.Flags      = flags;
   assign bus.Halted     = (state == ST_HALT);
   assign bus.Retired    = retired;

endmodule

// File: tb/tb_sips4_controller.sv
// Self-checking bench for sips4_controller with a
// behavioural model of decode, flags, load and halt.
module tb_sips4_controller;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sips4_controller_if #(.CNT_W(CW)) bus ();

   sips4_controller #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   bit         m_load;
   bit         m_halt;
   logic [3:0] m_flags;
   int         m_count;

   typedef struct packed {
      logic       rw;
      logic       mw;
      logic       as;
      logic       ps;
      logic       pw;
      logic [3:0] ac;
   } strb_t;

   localparam logic [15:0] NOP = 16'hC000;

   function automatic bit cond_ok(logic [2:0] c, logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return cy;
         3'd4: return !cy;
         3'd5: return n;
         3'd6: return !n;
         default: return v;
      endcase
   endfunction

   function automatic strb_t expect_strb(logic [15:0] i);
      strb_t e;
      int op;
      e  = '0;
      op = int'(i[15:11]);
      if (m_halt) begin
         e.ps = 1'b1;
         e.as = 1'b1;
         return e;
      end
      if (m_load) begin
         e.rw = 1'b1;
         return e;
      end
      if (op < 16) begin
         e.ac = i[14:11];
         e.as = i[0];
         e.rw = (op != 15);
         return e;
      end
      case (op)
         16: begin e.ps = 1'b1; e.as = i[0]; end
         17: begin e.ps = cond_ok(i[3:1], m_flags); e.as = i[0]; end
         18: begin e.ps = 1'b1; e.rw = 1'b1; e.as = i[0]; end
         21: e.mw = 1'b1;
         22: begin e.rw = 1'b1; e.as = 1'b1; end
         23: begin e.pw = 1'b1; e.as = 1'b1; end
         31: begin e.ps = 1'b1; e.as = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic strb_t observed();
      return {bus.RegWrite, bus.MemWrite, bus.ALUSrc,
              bus.PCSrc, bus.PortWrite, bus.ALUControl};
   endfunction

   task automatic drive(logic [15:0] i, logic [3:0] f, logic r);
      bus.Inst     = i;
      bus.ALUFlags = f;
      reset        = r;
      #2;
   endtask

   task automatic tick();
      int op;
      @(posedge clk);
      op = int'(bus.Inst[15:11]);
      if (reset) begin
         m_load  = 1'b0;
         m_halt  = 1'b0;
         m_flags = 4'b0000;
         m_count = 0;
      end else if (m_halt) begin
      end else if (m_load) begin
         m_load = 1'b0;
         m_count++;
      end else begin
         if (op < 16) m_flags = bus.ALUFlags;
         if (op == 20) m_load = 1'b1;
         else m_count++;
         if (op == 31) m_halt = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      drive(NOP, 4'b0000, 1'b1);
      tick();
      drive(NOP, 4'b0000, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      drive(NOP, 4'b1111, 1'b0);
      total++;
      if (bus.Halted !== 1'b0) begin
         bad++;
         $display("FAIL reset_halted got=%b want=0", bus.Halted);
      end
      total++;
      if (bus.Flags !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000", bus.Flags);
      end
      total++;
      if (bus.Retired !== 4'd0) begin
         bad++;
         $display("FAIL reset_retired got=%0d want=0", bus.Retired);
      end
      total++;
      if (observed() !== strb_t'(0)) begin
         bad++;
         $display("FAIL reset_nop_strobes got=%h want=0", observed());
      end
      tick();
   endtask

   task automatic test_alu();
      do_reset();
      drive(16'h0201, 4'b0100, 1'b0);
      total++;
      if (observed() !== strb_t'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0})) begin
         bad++;
         $display("FAIL alu_strobes got=%h want=%h", observed(),
                  strb_t'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}));
      end
      tick();
      drive(NOP, 4'b0000, 1'b0);
      total++;
      if (bus.Flags !== 4'b0100) begin
         bad++;
         $display("FAIL alu_flags got=%b want=0100", bus.Flags);
      end
      total++;
      if (bus.Retired !== 4'd1) begin
         bad++;
         $display("FAIL alu_retired got=%0d want=1", bus.Retired);
      end
      tick();
   endtask

   task automatic test_cmp_bcc();
      do_reset();
      drive(16'h7800, 4'b0100, 1'b0);
      total++;
      if (bus.RegWrite !== 1'b0 || bus.ALUControl !== 4'hF) begin
         bad++;
         $display("FAIL cmp_strobes got rw=%b ac=%h want rw=0 ac=f",
                  bus.RegWrite, bus.ALUControl);
      end
      tick();
      drive(16'h8802, 4'b0000, 1'b0);
      total++;
      if (bus.PCSrc !== 1'b1) begin
         bad++;
         $display("FAIL bcc_z_taken got=%b want=1", bus.PCSrc);
      end
      tick();
      drive(NOP, 4'b0000, 1'b0);
      total++;
      if (bus.Flags !== 4'b0100) begin
         bad++;
         $display("FAIL flags_hold_branch got=%b want=0100", bus.Flags);
      end
      tick();
      drive(16'h7800, 4'b0100, 1'b0);
      tick();
      drive(16'h8804, 4'b0000, 1'b0);
      total++;
      if (observed() !== strb_t'(0)) begin
         bad++;
         $display("FAIL bcc_nz_not_taken got=%h want=0", observed());
      end
      tick();
      drive(16'h0800, 4'b0000, 1'b0);
      tick();
      drive(16'h8802, 4'b0100, 1'b0);
      total++;
      if (bus.PCSrc !== 1'b0) begin
         bad++;
         $display("FAIL bcc_after_alu got=%b want=0", bus.PCSrc);
      end
      tick();
   endtask

   task automatic test_load();
      do_reset();
      drive(16'hA000, 4'b0000, 1'b0);
      total++;
      if (bus.RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL ld_cycle1_rw got=%b want=0", bus.RegWrite);
      end
      tick();
      drive(16'h0801, 4'b1111, 1'b0);
      total++;
      if (observed() !== strb_t'({1'b1, 8'h00})) begin
         bad++;
         $display("FAIL ld_cycle2_strobes got=%h want=%h", observed(),
                  strb_t'({1'b1, 8'h00}));
      end
      total++;
      if (bus.Retired !== 4'd0) begin
         bad++;
         $display("FAIL ld_retired_mid got=%0d want=0", bus.Retired);
      end
      tick();
      drive(16'h0800, 4'b0000, 1'b0);
      total++;
      if (bus.Retired !== 4'd1 || bus.Flags !== 4'b0000) begin
         bad++;
         $display("FAIL ld_after got ret=%0d flg=%b want ret=1 flg=0000",
                  bus.Retired, bus.Flags);
      end
      total++;
      if (bus.RegWrite !== 1'b1 || bus.ALUControl !== 4'h1) begin
         bad++;
         $display("FAIL ld_back_to_run got rw=%b ac=%h want rw=1 ac=1",
                  bus.RegWrite, bus.ALUControl);
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      drive(16'h0000, 4'b1010, 1'b0);
      tick();
      drive(16'hA000, 4'b0000, 1'b0);
      tick();
      do_reset();
      drive(NOP, 4'b0000, 1'b0);
      total++;
      if (bus.RegWrite !== 1'b0) begin
         bad++;
         $display("FAIL rst_load_rw got=%b want=0", bus.RegWrite);
      end
      total++;
      if (bus.Flags !== 4'b0000 || bus.Retired !== 4'd0) begin
         bad++;
         $display("FAIL rst_load_state got flg=%b ret=%0d want 0000/0",
                  bus.Flags, bus.Retired);
      end
      tick();
      drive(16'h1000, 4'b0000, 1'b0);
      total++;
      if (bus.RegWrite !== 1'b1) begin
         bad++;
         $display("FAIL rst_load_run got=%b want=1", bus.RegWrite);
      end
      tick();
   endtask

   task automatic test_halt();
      do_reset();
      drive(NOP, 4'b0000, 1'b0);
      tick();
      drive(16'hF850, 4'b0000, 1'b0);
      total++;
      if ({bus.RegWrite, bus.MemWrite, bus.PortWrite} !== 3'b000) begin
         bad++;
         $display("FAIL halt_issue_writes got=%b want=000",
                  {bus.RegWrite, bus.MemWrite, bus.PortWrite});
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(16'($urandom), 4'($urandom), 1'b0);
         total++;
         if (bus.Halted !== 1'b1 || bus.PCSrc !== 1'b1 ||
             bus.ALUSrc !== 1'b1 ||
             {bus.RegWrite, bus.MemWrite, bus.PortWrite} !== 3'b000) begin
            bad++;
            $display("FAIL halt_hold[%0d] got h=%b strb=%h want h=1 ps=as=1",
                     k, bus.Halted, observed());
         end
         total++;
         if (bus.Retired !== 4'd2 || bus.Flags !== 4'b0000) begin
            bad++;
            $display("FAIL halt_frozen[%0d] got ret=%0d flg=%b want 2/0000",
                     k, bus.Retired, bus.Flags);
         end
         tick();
      end
      do_reset();
      drive(NOP, 4'b0000, 1'b0);
      total++;
      if (bus.Halted !== 1'b0) begin
         bad++;
         $display("FAIL halt_reset got=%b want=0", bus.Halted);
      end
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 15; k++) begin
         drive(NOP, 4'($urandom), 1'b0);
         tick();
      end
      drive(16'h9800, 4'b1111, 1'b0);
      total++;
      if (bus.Retired !== 4'hF) begin
         bad++;
         $display("FAIL wrap_full got=%0d want=15", bus.Retired);
      end
      tick();
      drive(NOP, 4'b0000, 1'b0);
      total++;
      if (bus.Retired !== 4'd0 || bus.Flags !== 4'b0000 ||
          bus.Halted !== 1'b0 || observed() !== strb_t'(0)) begin
         bad++;
         $display("FAIL wrap_zero got ret=%0d flg=%b h=%b strb=%h want 0",
                  bus.Retired, bus.Flags, bus.Halted, observed());
      end
      tick();
   endtask

   task automatic test_random();
      int rst_left = 0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic [4:0]  op;
         logic [15:0] i;
         logic        r;
         strb_t       e;
         op = 5'($urandom_range(0, 31));
         if (op == 5'd31) op = 5'd24;
         i = {op, 11'($urandom)};
         if (rst_left == 0 && $urandom_range(0, 49) == 0) rst_left = 2;
         r = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         drive(i, 4'($urandom), r);
         e = expect_strb(i);
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL rand_strobes[%0d] inst=%h got=%h want=%h",
                     k, i, observed(), e);
         end
         total++;
         if (bus.Flags !== m_flags || bus.Halted !== m_halt) begin
            bad++;
            $display("FAIL rand_state[%0d] got flg=%b h=%b want flg=%b h=%b",
                     k, bus.Flags, bus.Halted, m_flags, m_halt);
         end
         total++;
         if (int'(bus.Retired) !== (m_count % (1 << CW))) begin
            bad++;
            $display("FAIL rand_retired[%0d] got=%0d want=%0d",
                     k, bus.Retired, m_count % (1 << CW));
         end
         tick();
      end
   endtask

   initial begin
      m_load   = 1'b0;
      m_halt   = 1'b0;
      m_flags  = 4'b0000;
      m_count  = 0;
      bus.Inst = NOP;
      bus.ALUFlags = 4'b0000;
      test_reset();
      test_alu();
      test_cmp_bcc();
      test_load();
      test_reset_mid_load();
      test_halt();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
